// File: rtl/req_arb_pkg.sv
// Shared constants and state type for the request one-hot arbiter.
// REQ_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
package req_arb_pkg;

    localparam int REQ_ARB_N     = 8;
    localparam int REQ_ARB_IDX_W = $clog2(REQ_ARB_N);

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

endpackage

// File: rtl/rr_onehot_select.sv
// Combinational one-hot pick from the pending vector.
// REQ_ARB_ROUND_ROBIN_EN: search from ptr with wrap; else highest index wins.
module rr_onehot_select
    import req_arb_pkg::*;
#(
    parameter int N  = REQ_ARB_N,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
`ifdef REQ_ARB_ROUND_ROBIN_EN
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
`endif
    output logic [N-1:0]  onehot
);

`ifdef REQ_ARB_ROUND_ROBIN_EN
    int k;

    // Scan farthest-from-ptr first so the nearest pending bit wins last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        k      = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (pending[k]) begin
                onehot    = '0;
                onehot[k] = 1'b1;
                idx       = IW'(k);
            end
        end
    end
`else
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/req_onehot_arbiter.sv
// Edge-captured request arbiter driving the 8-to-3 encoder i/en inputs.
// REQ_ARB_ROUND_ROBIN_EN enables the round-robin pointer.
module req_onehot_arbiter
    import req_arb_pkg::*;
#(
    parameter int N = REQ_ARB_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [N-1:0] grant,
    output logic         en,
    output logic [N-1:0] pending
);

    localparam int IW = $clog2(N);

    arb_state_e   state_q, state_d;
    logic [N-1:0] grant_q, grant_d;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] req_d_q;
    logic [N-1:0] rise, clr, sel;

`ifdef REQ_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [IW-1:0] sel_idx;

    rr_onehot_select #(.N(N), .IW(IW)) u_sel (
        .pending (pending_q),
        .ptr     (ptr_q),
        .idx     (sel_idx),
        .onehot  (sel)
    );
`else
    rr_onehot_select #(.N(N), .IW(IW)) u_sel (
        .pending (pending_q),
        .onehot  (sel)
    );
`endif

    always_comb begin
        rise    = req & ~req_d_q;
        clr     = '0;
        state_d = state_q;
        grant_d = grant_q;
`ifdef REQ_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    grant_d = sel;
                    state_d = GRANT;
`ifdef REQ_ARB_ROUND_ROBIN_EN
                    gidx_d  = sel_idx;
`endif
                end
            end
            GRANT: begin
                if (ack) begin
                    clr     = grant_q;
                    grant_d = '0;
                    state_d = IDLE;
`ifdef REQ_ARB_ROUND_ROBIN_EN
                    ptr_d   = (gidx_q == IW'(N - 1)) ? '0
                                                     : gidx_q + IW'(1);
`endif
                end
            end
        endcase
        // A new rising edge outranks the clear of the bit just served.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            pending_q <= '0;
            req_d_q   <= '0;
`ifdef REQ_ARB_ROUND_ROBIN_EN
            ptr_q     <= '0;
            gidx_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            req_d_q   <= req;
`ifdef REQ_ARB_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
`endif
        end
    end

    assign grant   = grant_q;
    assign en      = (state_q == GRANT);
    assign pending = pending_q;

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Directed bench for req_onehot_arbiter with a transaction-level model.
// Honours REQ_ARB_ROUND_ROBIN_EN for both model and literal expectations.
module tb_req_onehot_arbiter;

    localparam int N = 8;

`ifdef REQ_ARB_ROUND_ROBIN_EN
    localparam logic [N-1:0] FIRST81  = 8'h01;
    localparam logic [N-1:0] SECOND81 = 8'h80;
    localparam logic [N-1:0] FIRST03  = 8'h01;
    localparam logic [N-1:0] SECOND03 = 8'h02;
    localparam logic [N-1:0] POSTRST  = 8'h01;
`else
    localparam logic [N-1:0] FIRST81  = 8'h80;
    localparam logic [N-1:0] SECOND81 = 8'h01;
    localparam logic [N-1:0] FIRST03  = 8'h02;
    localparam logic [N-1:0] SECOND03 = 8'h01;
    localparam logic [N-1:0] POSTRST  = 8'h80;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         ack = 1'b0;
    logic [N-1:0] grant;
    logic         en;
    logic [N-1:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    req_onehot_arbiter #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .grant   (grant),
        .en      (en),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Model: set of pending indices, index being served (-1 = none).
    bit [N-1:0] m_pend = '0;
    bit [N-1:0] m_prev = '0;
    int         m_cur  = -1;
`ifdef REQ_ARB_ROUND_ROBIN_EN
    int         m_ptr  = 0;
`endif

    function automatic int pick(input bit [N-1:0] p);
`ifdef REQ_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < N; i++)
            if (p[(m_ptr + i) % N]) return (m_ptr + i) % N;
`else
        for (int i = N - 1; i >= 0; i--)
            if (p[i]) return i;
`endif
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = '0;
            m_prev = '0;
            m_cur  = -1;
`ifdef REQ_ARB_ROUND_ROBIN_EN
            m_ptr  = 0;
`endif
        end else begin
            bit [N-1:0] np;
            int         nc;
            np = m_pend;
            nc = m_cur;
            if (m_cur >= 0 && ack) begin
                np[m_cur] = 1'b0;
`ifdef REQ_ARB_ROUND_ROBIN_EN
                m_ptr = (m_cur + 1) % N;
`endif
                nc = -1;
            end else if (m_cur < 0 && m_pend != 0) begin
                nc = pick(m_pend);
            end
            np     = np | (req & ~m_prev);
            m_prev = req;
            m_pend = np;
            m_cur  = nc;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        eg = (m_cur < 0) ? '0 : (N'(1) << m_cur);
        chk("model_grant", grant, eg);
        chk("model_en", {{(N-1){1'b0}}, en}, {{(N-1){1'b0}}, m_cur >= 0});
        chk("model_pending", pending, m_pend);
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        step();
        step();
        chk("rst_grant", grant, 8'h00);
        chk("rst_pending", pending, 8'h00);
        chk("rst_en", {7'd0, en}, 8'h00);
        rst = 1'b0;

        req = 8'h81;
        step();
        chk("p81_pending", pending, 8'h81);
        step();
        chk("p81_first", grant, FIRST81);
        ack = 1'b1;
        step();
        ack = 1'b0;
        req = 8'h00;
        chk("p81_left", pending, SECOND81);
        chk("p81_bubble_en", {7'd0, en}, 8'h00);
        step();
        chk("p81_second", grant, SECOND81);
        ack = 1'b1;
        step();
        ack = 1'b0;
        req = 8'h03;
        step();
        step();
        chk("p03_first", grant, FIRST03);
        ack = 1'b1;
        step();
        ack = 1'b0;
        req = 8'h00;
        chk("p03_left", pending, SECOND03);
        step();
        chk("p03_second", grant, SECOND03);
        ack = 1'b1;
        step();
        ack = 1'b0;

        req = 8'h10;
        step();
        chk("s10_pending", pending, 8'h10);
        chk("s10_en_early", {7'd0, en}, 8'h00);
        step();
        chk("s10_grant", grant, 8'h10);
        chk("s10_en", {7'd0, en}, 8'h01);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("s10_ack_en", {7'd0, en}, 8'h00);
        chk("s10_ack_pending", pending, 8'h00);
        step();
        step();
        chk("s10_held_pending", pending, 8'h00);

        req = 8'h08;
        step();
        step();
        chk("sc_grant", grant, 8'h08);
        req = 8'h00;
        step();
        req = 8'h08;
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("sc_pending", pending, 8'h08);
        step();
        chk("sc_regrant", grant, 8'h08);
        ack = 1'b1;
        req = 8'h00;
        step();
        ack = 1'b0;

        req = 8'h02;
        step();
        step();
        chk("hold_grant0", grant, 8'h02);
        for (int i = 0; i < 10; i++) begin
            req = (i % 2 == 0) ? 8'h26 : 8'h52;
            step();
            chk("hold_grant", grant, 8'h02);
        end
        chk("hold_pending", pending, 8'h76);

        req = 8'hFF;
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", grant, 8'h00);
        chk("arst_en", {7'd0, en}, 8'h00);
        chk("arst_pending", pending, 8'h00);
        step();
        step();
        rst = 1'b0;
        step();
        chk("rel_pending", pending, 8'hFF);
        chk("rel_en", {7'd0, en}, 8'h00);
        step();
        chk("rel_grant", grant, POSTRST);

        ack = 1'b1;
        req = 8'h00;
        repeat (6) step();
        ack = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
